// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
//
// Frequency/period meter for a square wave that is asynchronous to clk.
// The input is synchronized, its rising edges are detected, and the number of
// clk cycles between successive rising edges (period) is reported together
// with the number of those cycles during which the synchronized signal was
// high (high_time). A stall detector raises timeout when no rising edge
// arrives within TIMEOUT cycles. An optional lock detector raises locked once
// LOCK_COUNT consecutive periods have each differed from their predecessor
// by no more than TOL cycles.
//
// Optional feature macro:
//   FREQ_METER_LOCK_EN  - when defined, builds the period comparator and
//                         match counter that drive locked. When undefined,
//                         locked is a constant 0.
//
// Parameters:
//   CNT_W       - width of period/high_time and the internal counters
//   SYNC_STAGES - synchronizer depth on sig_in (>= 2)
//   TIMEOUT     - cycles without a rising edge before timeout (< 2**CNT_W)
//   LOCK_COUNT  - consecutive in-tolerance periods required for lock (>= 1)
//   TOL         - allowed absolute period difference between measurements
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous, active-high reset
//   en         in   measurement enable (level); low forces IDLE
//   sig_in     in   asynchronous signal under test
//   period     out  last measured period in clk cycles
//   high_time  out  clk cycles the synchronized signal was high in that period
//   meas_valid out  one-cycle pulse when period/high_time update
//   timeout    out  level; no rising edge within TIMEOUT cycles
//   locked     out  level; period stable (0 unless FREQ_METER_LOCK_EN)
//
// All outputs come straight from flops. The synchronizer adds a constant
// delay to every edge, so it does not bias the measured period.
// -----------------------------------------------------------------------------
module freq_meter #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000000,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             locked
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_MEAS = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_dly_q;
  logic                   re;

  state_e                 state_q,  state_d;
  logic [CNT_W-1:0]       cnt_q,    cnt_d;
  logic [CNT_W-1:0]       hcnt_q,   hcnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q,   high_d;
  logic                   mv_q,     mv_d;
  logic                   to_q,     to_d;

  // ---- synchronizer and rising-edge detect --------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      s_dly_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_dly_q <= s;
    end
  end

  assign s  = sync_q[SYNC_STAGES-1];
  assign re = s & ~s_dly_q;

  // ---- measurement FSM: next state ----------------------------------------
  // cnt doubles as the ARM wait timer and the MEAS period counter. It starts
  // at 1 because the cycle carrying the edge is itself the first cycle of the
  // new period; hcnt likewise starts at 1 since s is high on that cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    mv_d     = 1'b0;
    to_d     = to_q;

    if (!en) begin
      // Disabling drops any partial count without reporting it.
      state_d = S_IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
      to_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
          cnt_d   = ONE_C;
          hcnt_d  = '0;
        end

        S_ARM: begin
          if (re) begin
            // First edge only opens a period; nothing is reported.
            state_d = S_MEAS;
            cnt_d   = ONE_C;
            hcnt_d  = ONE_C;
          end else if (cnt_q >= TIMEOUT_C) begin
            to_d  = 1'b1;
            cnt_d = ONE_C;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end

        S_MEAS: begin
          // The edge is tested before the timeout so a period of exactly
          // TIMEOUT cycles is still measured.
          if (re) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            mv_d     = 1'b1;
            to_d     = 1'b0;
            cnt_d    = ONE_C;
            hcnt_d   = ONE_C;
          end else if (cnt_q >= TIMEOUT_C) begin
            state_d = S_ARM;
            to_d    = 1'b1;
            cnt_d   = ONE_C;
            hcnt_d  = '0;
          end else begin
            cnt_d = cnt_q + ONE_C;
            if (s) begin
              hcnt_d = hcnt_q + ONE_C;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  // ---- measurement FSM: registers -----------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      to_q     <= to_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = mv_q;
  assign timeout    = to_q;

`ifdef FREQ_METER_LOCK_EN
  // ---- lock detector ------------------------------------------------------
  localparam int               MW     = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0]    LOCK_C = MW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] TOL_C  = CNT_W'(TOL);

  logic [CNT_W-1:0] prev_q,   prev_d;
  logic [MW-1:0]    match_q,  match_d;
  logic [MW-1:0]    match_inc;
  logic             first_q,  first_d;
  logic             locked_q, locked_d;
  logic             take;
  logic             lost;
  logic [CNT_W-1:0] diff;

  // Same conditions the FSM uses to report a period or to time out in MEAS.
  assign take = en & (state_q == S_MEAS) & re;
  assign lost = en & (state_q == S_MEAS) & ~re & (cnt_q >= TIMEOUT_C);

  assign diff      = (cnt_q >= prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);
  assign match_inc = (match_q < LOCK_C) ? (match_q + MW'(1)) : match_q;

  always_comb begin
    prev_d   = prev_q;
    match_d  = match_q;
    first_d  = first_q;
    locked_d = locked_q;

    if (!en || (state_q != S_MEAS) || lost) begin
      // Outside a running measurement the history is void; the next
      // reported period only seeds the comparator.
      match_d  = '0;
      first_d  = 1'b1;
      locked_d = 1'b0;
    end else if (take) begin
      prev_d = cnt_q;
      if (first_q) begin
        first_d = 1'b0;
      end else if (diff <= TOL_C) begin
        match_d  = match_inc;
        locked_d = (match_inc == LOCK_C);
      end else begin
        match_d  = '0;
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      match_q  <= '0;
      first_q  <= 1'b1;
      locked_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      match_q  <= match_d;
      first_q  <= first_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_freq_meter
//
// Drives sig_in as a sequence of pulses (h cycles high, l cycles low). Each
// rising edge closes the previous pulse, so the reference model pushes the
// expected {period, high_time, locked} of the previous pulse when the next
// one starts, provided that pulse was measurable (an armed edge came before
// it and it did not outlast TIMEOUT). A forked monitor pops and compares on
// every meas_valid.
// -----------------------------------------------------------------------------
module tb_freq_meter;

  localparam int CNT_W      = 16;
  localparam int SS         = 2;
  localparam int TIMEOUT    = 50;
  localparam int LOCK_COUNT = 4;
  localparam int TOL        = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;
  logic             locked;

  typedef struct {
    int p;
    int h;
    bit lk;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];
  bit   have_prev = 1'b0;
  int   prev_p    = 0;
  int   prev_h    = 0;
  int   last_exp_p = 0;
  int   checks = 0;
  int   errors = 0;

  freq_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SS),
    .TIMEOUT    (TIMEOUT),
    .LOCK_COUNT (LOCK_COUNT),
    .TOL        (TOL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .timeout   (timeout),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Locked holds when the last LOCK_COUNT consecutive period pairs since
  // arming all lie within TOL of each other.
  function automatic bit lock_model();
    bit ok;
    int n;
    int d;
    ok = 1'b0;
`ifdef FREQ_METER_LOCK_EN
    n = hist.size();
    if (n >= LOCK_COUNT + 1) begin
      ok = 1'b1;
      for (int i = n - LOCK_COUNT; i < n; i++) begin
        d = hist[i] - hist[i-1];
        if (d < 0) d = -d;
        if (d > TOL) ok = 1'b0;
      end
    end
`else
    n = 0;
    d = n;
`endif
    return ok;
  endfunction

  // Called at each rising edge of sig_in with the shape of the pulse it opens.
  task automatic model_edge(input int h, input int p);
    exp_t e;
    if (have_prev) begin
      hist.push_back(prev_p);
      e.p  = prev_p;
      e.h  = prev_h;
      e.lk = lock_model();
      exp_q.push_back(e);
      last_exp_p = prev_p;
    end
    have_prev = 1'b1;
    prev_p    = p;
    prev_h    = h;
    if (p > TIMEOUT) begin
      // The meter gives up before the next edge, which then only re-arms.
      have_prev = 1'b0;
      hist.delete();
    end
  endtask

  // mode: 0 plain, 1 check timeout timing, 2 drop en mid-low, 3 async reset
  task automatic pulse(input int h, input int l, input int mode);
    model_edge(h, h + l);
    for (int i = 0; i < h + l; i++) begin
      sig_in = (i < h);
      if (mode == 2 && i == h + 3) en = 1'b0;
      if (mode == 2 && i == h + 6) en = 1'b1;
      if (mode == 3 && i == h + 5) rst = 1'b0;
      @(posedge clk);
      #1;
      // The edge reaches the counter SS+1 clocks after it is driven; the
      // flag registers one clock after the counter reaches TIMEOUT.
      if (mode == 1 && i + 1 == TIMEOUT + SS)
        chk("timeout_early", timeout, 0);
      if (mode == 1 && i + 1 == TIMEOUT + SS + 1) begin
        chk("timeout_set", timeout, 1);
        chk("timeout_unlock", locked, 0);
      end
      if (mode == 2 && i == h + 3) begin
        chk("drop_timeout", timeout, 0);
        chk("drop_locked", locked, 0);
        chk("drop_no_valid", meas_valid, 0);
      end
      if (mode == 3 && i == h + 2) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_locked", locked, 0);
      end
    end
    if (mode == 2 || mode == 3) begin
      have_prev = 1'b0;
      hist.delete();
    end
    if (mode == 3) last_exp_p = 0;
  endtask

  task automatic monitor();
    exp_t e;
    bit   prev_mv;
    prev_mv = 1'b0;
    forever begin
      @(negedge clk);
      if (meas_valid === 1'b1) begin
        chk("valid_gap", prev_mv, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got period=%0d high=%0d, expected no measurement",
                   period, high_time);
        end else begin
          e = exp_q.pop_front();
          chk("period", period, e.p);
          chk("high_time", high_time, e.h);
          chk("locked", locked, e.lk);
        end
      end
      prev_mv = (meas_valid === 1'b1);
    end
  endtask

  initial begin
    int lp[7];
    int h;
    int l;
    int base;
    int p;

    rst    = 1'b1;
    en     = 1'b0;
    sig_in = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_period", period, 0);
    chk("reset_high", high_time, 0);
    chk("reset_valid", meas_valid, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_locked", locked, 0);
    rst = 1'b0;
    en  = 1'b1;

    // Divide-by-6 waveform, then the minimum period of 2.
    repeat (6) pulse(3, 3, 0);
    repeat (8) pulse(1, 1, 0);

    // Long gap forces a timeout, so the lock sequence starts from ARM.
    pulse(1, 60, 0);
    lp = '{10, 10, 11, 10, 10, 14, 10};
    for (int i = 0; i < 7; i++) pulse(5, lp[i] - 5, 0);

    // Stall after two edges.
    pulse(3, 3, 0);
    pulse(3, 80, 1);
    pulse(4, 4, 0);
    chk("timeout_held_on_arm_edge", timeout, 1);
    pulse(4, 4, 0);
    chk("timeout_cleared", timeout, 0);

    // Period of exactly TIMEOUT is measured; one more cycle is a stall.
    pulse(20, 30, 0);
    pulse(2, 2, 0);
    chk("edge_wins_timeout", timeout, 0);
    pulse(20, 31, 0);
    pulse(2, 2, 0);
    chk("timeout_past_limit", timeout, 1);
    pulse(2, 2, 0);
    chk("timeout_recovered", timeout, 0);

    // Enable drop mid-period.
    pulse(4, 4, 0);
    pulse(4, 4, 0);
    pulse(4, 10, 2);
    pulse(5, 5, 0);
    chk("drop_period_hold", period, last_exp_p);
    pulse(5, 5, 0);
    pulse(5, 5, 0);

    // Asynchronous reset mid-measurement, then a cold start.
    pulse(3, 3, 0);
    pulse(3, 3, 0);
    pulse(4, 12, 3);
    chk("cold_period", period, 0);
    repeat (3) pulse(3, 3, 0);

    // Random periods, occasionally long enough to stall.
    for (int n = 0; n < 60; n++) begin
      h = $urandom_range(1, 9);
      l = ($urandom_range(0, 9) == 0) ? $urandom_range(35, 50) : $urandom_range(1, 9);
      pulse(h, l, 0);
    end

    // Random near-constant periods to exercise lock and its loss.
    for (int r = 0; r < 4; r++) begin
      base = $urandom_range(6, 20);
      for (int n = 0; n < 9; n++) begin
        p = base + $urandom_range(0, 1);
        pulse(p / 2, p - p / 2, 0);
      end
      pulse(2, 2, 0);
    end

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("missing_valid", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Clock-domain frequency/period meter: the receive-side counterpart to the frequency divider. It samples an external or divided square wave, counts `clk` cycles between successive rising edges, and reports period and high time per cycle. It also flags a stall (no edges) and, optionally, lock once the period is stable. It sits beside the divider so loopback and board-level clock checks can confirm the divide ratio actually produced.

## Interface
- `CNT_W`, 32: width of the period, high-time and internal counters.
- `SYNC_STAGES`, 2: synchronizer flops on `sig_in`; must be ≥2.
- `TIMEOUT`, 1000000: cycles without a rising edge before `timeout` asserts. Must be < 2^CNT_W.
- `LOCK_COUNT`, 4: consecutive in-tolerance measurements required for `locked`; must be ≥1.
- `TOL`, 1: allowed absolute period difference, in cycles, between consecutive measurements.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: measurement enable; level.
- `sig_in` in 1: asynchronous signal under test.
- `period` out CNT_W: last measured period in `clk` cycles.
- `high_time` out CNT_W: `clk` cycles the synchronized signal was high in that period.
- `meas_valid` out 1: one-cycle pulse when `period`/`high_time` update.
- `timeout` out 1: level; no rising edge within TIMEOUT cycles.
- `locked` out 1: level; period stable (see Configuration).

## Operation
- **Synchronizer and edge detect:** `sig_in` passes through SYNC_STAGES flops to produce `s`. A rising edge `re` = `s` & ~`s_d`, where `s_d` is `s` delayed one cycle.
- **State IDLE:** entered on reset or when `en`=0. Counters are cleared; `timeout` and `locked` are cleared; `period`/`high_time` hold their values. IDLE→ARM when `en`=1.
- **State ARM:** waits for the first `re`. On `re`, go to MEAS with `cnt`←1 and `hcnt`←1. This first edge produces no `meas_valid`.
- **State MEAS:** each cycle `cnt`←`cnt`+1, and `hcnt`←`hcnt`+1 when `s`=1. On `re`:
  - `period`←`cnt`, `high_time`←`hcnt`, `meas_valid`←1.
  - Then `cnt`←1, `hcnt`←1.
  - `timeout`←0.
- **Timeout:** if `cnt` reaches TIMEOUT in MEAS, or the ARM wait reaches TIMEOUT, then `timeout`←1, `locked`←0 and the state goes to ARM. `period`/`high_time` hold.
- **Arithmetic:** all counters are unsigned CNT_W. `cnt` never exceeds TIMEOUT, so there is no wrap. `high_time` ≤ `period` always.
- **Boundary cases:**
  - `re` and TIMEOUT in the same cycle: the edge wins (a measurement is taken and `timeout` stays 0).
  - `en` falling mid-period: the partial count is discarded and no `meas_valid` is produced.
  - `rst` mid-operation: returns immediately to IDLE with reset values.
  - Minimum measurable period is 2 cycles.

## Timing
- Reset values: `period`=0, `high_time`=0, `meas_valid`=0, `timeout`=0, `locked`=0, state IDLE.
- Latency: `meas_valid` pulses SYNC_STAGES+1 cycles after the `clk` edge that first samples `sig_in` high. This latency is constant, so it does not bias `period`.
- `period`, `high_time` and `locked` update in the same cycle `meas_valid`=1. They are stable otherwise.
- `meas_valid` is never high on two consecutive cycles unless `period`=1, which cannot occur.
- Register-only outputs; no combinational path from input to output.

## Configuration
- Macro: `FREQ_METER_LOCK_EN`.
- **Defined:** a match counter compares each new `period` against the previous one.
  - If |new−prev| ≤ TOL, the counter increments (saturating); otherwise it clears to 0.
  - The first measurement after ARM only loads `prev` and does not count.
  - `locked`←1 on the `meas_valid` of the LOCK_COUNT-th consecutive match.
  - `locked` clears on a mismatch, timeout, `en`=0 or `rst`.
- **Undefined:** no comparator or match counter is built, and `locked` is tied to 0.

## Test plan
- **Divide-by-6 input.** Stimulus: `sig_in` from the divider with N=5 (3 high, 3 low), `en`=1. Required: first `meas_valid` on the second rising edge, `period`=6, `high_time`=3, then every 6 cycles.
- **Timeout.** Stimulus: TIMEOUT=50 and `sig_in` held at 0 after two edges. Required: `timeout`=1 exactly 50 cycles after the last edge, state ARM, `locked`=0. The next two edges clear `timeout` and give a valid measurement.
- **Lock (macro defined).** Stimulus: LOCK_COUNT=4, TOL=1, periods 10,10,11,10,10,14. Required: `locked` rises on the 5th `meas_valid` (4 consecutive matches) and falls on the `meas_valid` reporting 14. Without the macro, `locked` stays 0 throughout.
- **Enable drop.** Stimulus: `en` dropped for 3 cycles mid-period, then raised. Required: no `meas_valid` from the partial period; the first new `meas_valid` comes only after two fresh rising edges; `period` holds its old value meanwhile.
- **Async reset.** Stimulus: `rst` asserted mid-MEAS, off a clock edge. Required: all outputs are 0 immediately. After release, behaviour matches a cold start.
- **Minimum period.** Stimulus: `sig_in` alternating every cycle (period 2). Required: `period`=2 and `high_time`=1 on every `meas_valid`.
